// File: rtl/ext_bus_pkg.sv
// Shared encodings for the external bus sequencer and bus_control's strobe decoder.
package ext_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    // {rom_rd_b, ram_rd_b, ram_wr_b}, active low
    localparam logic [2:0] STB_ROM_RD = 3'b011;
    localparam logic [2:0] STB_RAM_RD = 3'b101;
    localparam logic [2:0] STB_RAM_WR = 3'b110;
    localparam logic [2:0] STB_NONE   = 3'b111;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/ext_bus_arbiter.sv
// Fetch/data arbiter; one-hot grant {data, fetch}. EXT_BUS_SEQUENCER_RR_EN selects
// round-robin on ties, otherwise data always wins.
module ext_bus_arbiter
    import ext_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       take,
    output logic [1:0] grant
);

`ifdef EXT_BUS_SEQUENCER_RR_EN
    logic last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= GNT_FETCH;
        else if (take)
            last_gnt <= grant[1];
    end

    always_comb begin
        grant = 2'b00;
        if (fetch_req && data_req)
            grant = (last_gnt == GNT_FETCH) ? 2'b10 : 2'b01;
        else if (data_req)
            grant = 2'b10;
        else if (fetch_req)
            grant = 2'b01;
    end
`else
    logic unused_ok;
    assign unused_ok = clk ^ rst_n ^ take;

    always_comb begin
        grant = 2'b00;
        if (data_req)
            grant = 2'b10;
        else if (fetch_req)
            grant = 2'b01;
    end
`endif

endmodule

// File: rtl/ext_bus_sequencer.sv
// External memory bus sequencer: arbitrates fetch/data requests and runs a
// SETUP/STROBE/HOLD cycle toward bus_control. Option: EXT_BUS_SEQUENCER_RR_EN.
module ext_bus_sequencer
    import ext_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        ext_bus_sequencer_clk_i,
    input  logic        ext_bus_sequencer_rst_b_i,
    input  logic        ext_bus_sequencer_fetch_req_i,
    input  logic [15:0] ext_bus_sequencer_fetch_addr_i,
    output logic        ext_bus_sequencer_fetch_ack_o,
    output logic [7:0]  ext_bus_sequencer_fetch_data_o,
    input  logic        ext_bus_sequencer_data_req_i,
    input  logic        ext_bus_sequencer_data_we_i,
    input  logic [15:0] ext_bus_sequencer_data_addr_i,
    input  logic [7:0]  ext_bus_sequencer_data_wdata_i,
    output logic        ext_bus_sequencer_data_ack_o,
    output logic [7:0]  ext_bus_sequencer_data_rdata_o,
    output logic [15:0] ext_bus_sequencer_ext_addr_o,
    output logic [7:0]  ext_bus_sequencer_ext_data_o,
    input  logic [7:0]  ext_bus_sequencer_ext_data_i,
    output logic        ext_bus_sequencer_ext_rom_rd_b_o,
    output logic        ext_bus_sequencer_ext_ram_rd_b_o,
    output logic        ext_bus_sequencer_ext_ram_wr_b_o,
    output logic        ext_bus_sequencer_busy_o
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic       gnt_data;
    logic       op_we;
    logic [3:0] cnt;
    logic [2:0] stb;
    logic [1:0] grant;
    logic       take;

    assign take = (state == ST_IDLE) && (|grant);

    ext_bus_arbiter u_arb (
        .clk       (ext_bus_sequencer_clk_i),
        .rst_n     (ext_bus_sequencer_rst_b_i),
        .fetch_req (ext_bus_sequencer_fetch_req_i),
        .data_req  (ext_bus_sequencer_data_req_i),
        .take      (take),
        .grant     (grant)
    );

    assign {ext_bus_sequencer_ext_rom_rd_b_o,
            ext_bus_sequencer_ext_ram_rd_b_o,
            ext_bus_sequencer_ext_ram_wr_b_o} = stb;
    assign ext_bus_sequencer_busy_o = (state != ST_IDLE);

    always_ff @(posedge ext_bus_sequencer_clk_i or negedge ext_bus_sequencer_rst_b_i) begin
        if (!ext_bus_sequencer_rst_b_i) begin
            state                          <= ST_IDLE;
            gnt_data                       <= GNT_FETCH;
            op_we                          <= 1'b0;
            cnt                            <= '0;
            stb                            <= STB_NONE;
            ext_bus_sequencer_ext_addr_o   <= '0;
            ext_bus_sequencer_ext_data_o   <= '0;
            ext_bus_sequencer_fetch_ack_o  <= 1'b0;
            ext_bus_sequencer_data_ack_o   <= 1'b0;
            ext_bus_sequencer_fetch_data_o <= '0;
            ext_bus_sequencer_data_rdata_o <= '0;
        end else begin
            ext_bus_sequencer_fetch_ack_o <= 1'b0;
            ext_bus_sequencer_data_ack_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        gnt_data <= grant[1];
                        op_we    <= grant[1] & ext_bus_sequencer_data_we_i;
                        ext_bus_sequencer_ext_addr_o <= grant[1] ? ext_bus_sequencer_data_addr_i
                                                                 : ext_bus_sequencer_fetch_addr_i;
                        ext_bus_sequencer_ext_data_o <= (grant[1] && ext_bus_sequencer_data_we_i)
                                                        ? ext_bus_sequencer_data_wdata_i : 8'h00;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    stb   <= (gnt_data == GNT_FETCH) ? STB_ROM_RD :
                             op_we                   ? STB_RAM_WR : STB_RAM_RD;
                    cnt   <= CNT_INIT;
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt == 4'd0) begin
                        // read data is sampled on the same edge that releases the strobe
                        stb   <= STB_NONE;
                        state <= ST_HOLD;
                        if (gnt_data == GNT_FETCH)
                            ext_bus_sequencer_fetch_data_o <= ext_bus_sequencer_ext_data_i;
                        else if (!op_we)
                            ext_bus_sequencer_data_rdata_o <= ext_bus_sequencer_ext_data_i;
                        ext_bus_sequencer_fetch_ack_o <= (gnt_data == GNT_FETCH);
                        ext_bus_sequencer_data_ack_o  <= (gnt_data == GNT_DATA);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    ext_bus_sequencer_ext_data_o <= 8'h00;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
